// File: rtl/instr_stream_loader_pkg.sv
// Shared constants and types for the UART-fed instruction store.
package instr_loader_pkg;

  localparam int OPC_W_DEF       = 4;
  localparam int SEL_W_DEF       = 2;
  localparam int BYTES_PER_INSTR = 6;

  // Position of each byte within one received frame
  localparam logic [2:0] B_OPC  = 3'd0;
  localparam logic [2:0] B_SEL  = 3'd1;
  localparam logic [2:0] B_OP1H = 3'd2;
  localparam logic [2:0] B_OP1L = 3'd3;
  localparam logic [2:0] B_OP2H = 3'd4;
  localparam logic [2:0] B_OP2L = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ASM  = 2'd1,
    S_FULL = 2'd2
  } load_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge
// detector, so a held button yields exactly one pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);

  logic [2:0] sh_q, sh_d;

  // shift the raw button level through the sync chain plus one history flop
  always_comb begin
    sh_d = {sh_q[1:0], btn_in};
  end

  // sync chain registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/instr_stream_loader.sv
// Instruction store filled from a UART byte stream. Six bytes form one word
// {opc, sel, op1h, op1l, op2h, op2l}; words are appended until the store is
// full. Provides a registered fetch port and a button-browsed debug view.
//
//  state  | meaning
//  S_IDLE | waiting for the first byte of a frame
//  S_ASM  | part of a frame received, inter-byte timer running
//  S_FULL | DEPTH words stored, further bytes flag overflow
module instr_stream_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int TIMEOUT_CYC = 20000,
  localparam int AW         = $clog2(DEPTH),
  localparam int INSTR_W    = OPC_W + SEL_W + 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               clear,
  input  logic [11:0]        addr,
  output logic [INSTR_W-1:0] instruction,
  output logic [AW:0]        instr_count,
  output logic               full,
  output logic               overflow,
  output logic               frame_err,
  output logic               word_wr,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               btn_page,
  output logic [AW-1:0]      debug_idx,
  output logic [7:0]         debug_a,
  output logic [7:0]         debug_b,
  output logic [7:0]         debug_c
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int FW = INSTR_W - 8;   // everything except the last byte

  load_state_t        state_q, state_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [AW:0]        count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               overflow_q, overflow_d;
  logic               frame_err_q, frame_err_d;
  logic               word_wr_q, word_wr_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic [AW-1:0]      debug_idx_q, debug_idx_d;
  logic [7:0]         dbg_a_q, dbg_a_d, dbg_b_q, dbg_b_d, dbg_c_q, dbg_c_d;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [AW-1:0]      wr_ptr;
  logic               next_p, prev_p;
  logic [INSTR_W-1:0] dbg_word;

  // write pointer never wraps: FULL blocks writes once it would
  assign wr_ptr = count_q[AW-1:0];

  // byte assembly, commit and timeout next-state logic
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    frame_d     = frame_q;
    timer_d     = timer_q;
    count_d     = count_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    word_wr_d   = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = {frame_q, rx_data};

    if (clear) begin
      state_d     = S_IDLE;
      byte_idx_d  = '0;
      timer_d     = '0;
      count_d     = '0;
      valid_d     = '0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ASM: begin
          if (rx_valid) begin
            timer_d = '0;
            if (byte_idx_q == B_OP2L) begin
              mem_we          = 1'b1;
              valid_d[wr_ptr] = 1'b1;
              count_d         = count_q + 1'b1;
              word_wr_d       = 1'b1;
              byte_idx_d      = '0;
              state_d         = (count_q == (AW+1)'(DEPTH - 1)) ? S_FULL : S_IDLE;
            end else begin
              case (byte_idx_q)
                B_OPC:   frame_d[FW-1 -: OPC_W] = rx_data[OPC_W-1:0];
                B_SEL:   frame_d[24 +: SEL_W]   = rx_data[SEL_W-1:0];
                B_OP1H:  frame_d[16 +: 8]       = rx_data;
                B_OP1L:  frame_d[8 +: 8]        = rx_data;
                B_OP2H:  frame_d[0 +: 8]        = rx_data;
                default: frame_d                = frame_q;
              endcase
              byte_idx_d = byte_idx_q + 3'd1;
              state_d    = S_ASM;
            end
          end else if (state_q == S_ASM) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
              byte_idx_d  = '0;
              timer_d     = '0;
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (rx_valid) overflow_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // fetch port: unwritten or out-of-range slots read as zero
  always_comb begin
    instruction_d = '0;
    if ((32'(addr) < DEPTH) && valid_q[addr[AW-1:0]]) instruction_d = mem[addr[AW-1:0]];
  end

  // debug index stepping with wrap; simultaneous presses cancel
  always_comb begin
    debug_idx_d = debug_idx_q;
    if (next_p && !prev_p) begin
      debug_idx_d = (debug_idx_q == AW'(DEPTH - 1)) ? '0 : debug_idx_q + 1'b1;
    end else if (prev_p && !next_p) begin
      debug_idx_d = (debug_idx_q == '0) ? AW'(DEPTH - 1) : debug_idx_q - 1'b1;
    end
  end

  // debug display mux over the selected slot and page
  always_comb begin
    dbg_word = valid_q[debug_idx_q] ? mem[debug_idx_q] : '0;
    if (btn_page) begin
      dbg_a_d = dbg_word[23:16];
      dbg_b_d = dbg_word[15:8];
      dbg_c_d = dbg_word[7:0];
    end else begin
      dbg_a_d = 8'(dbg_word[INSTR_W-1 -: OPC_W]);
      dbg_b_d = 8'(dbg_word[32 +: SEL_W]);
      dbg_c_d = dbg_word[31:24];
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_idx_q    <= '0;
      frame_q       <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      word_wr_q     <= 1'b0;
      instruction_q <= '0;
      debug_idx_q   <= '0;
      dbg_a_q       <= '0;
      dbg_b_q       <= '0;
      dbg_c_q       <= '0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      frame_q       <= frame_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
      frame_err_q   <= frame_err_d;
      word_wr_q     <= word_wr_d;
      instruction_q <= instruction_d;
      debug_idx_q   <= debug_idx_d;
      dbg_a_q       <= dbg_a_d;
      dbg_b_q       <= dbg_b_d;
      dbg_c_q       <= dbg_c_d;
    end
  end

  // instruction storage, deliberately not reset; the valid bitmap masks stale data
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wdata;
  end

  btn_edge_sync u_sync_next (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_next),
    .pulse  (next_p)
  );

  btn_edge_sync u_sync_prev (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_prev),
    .pulse  (prev_p)
  );

  assign instruction = instruction_q;
  assign instr_count = count_q;
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign word_wr     = word_wr_q;
  assign debug_idx   = debug_idx_q;
  assign debug_a     = dbg_a_q;
  assign debug_b     = dbg_b_q;
  assign debug_c     = dbg_c_q;

endmodule
